// File: rtl/led_fade_pkg.sv
// Shared types and step arithmetic for the LED fade sequencer.
// Brightness is 8 bits; channel index is 4 bits (up to 16 channels).
package led_fade_pkg;

  localparam int NUM_CH_MAX = 16;
  localparam int CH_W       = 4;
  localparam int BRIGHT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef logic [BRIGHT_W-1:0] bright_t;

  // One step from cur toward tgt, clamped at tgt; a zero step acts as 1
  function automatic bright_t step_toward(
    input bright_t cur,
    input bright_t tgt,
    input bright_t step
  );
    logic [BRIGHT_W:0] st;
    logic [BRIGHT_W:0] r;
    st = (step == '0) ? (BRIGHT_W+1)'(1) : {1'b0, step};
    if (cur < tgt) begin
      r = {1'b0, cur} + st;
      return (r >= {1'b0, tgt}) ? tgt : r[BRIGHT_W-1:0];
    end
    r = {1'b0, cur} - st;
    if (r[BRIGHT_W] || (r[BRIGHT_W-1:0] <= tgt))
      return tgt;
    return r[BRIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/led_fade_sequencer_if.sv
// Command, CPU and device bus bundle for the fade sequencer.
// master = CPU/command side plus device read data; slave = sequencer.
interface led_fade_sequencer_if #(
  parameter int ADDR_W = 5
);
  import led_fade_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  bright_t           cmd_target;
  bright_t           cmd_step;

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_enable;
  logic              cpu_mode;
  bright_t           cpu_data_in;
  bright_t           cpu_data_out;

  logic [ADDR_W-1:0] dev_address;
  logic              dev_enable;
  logic              dev_mode;
  bright_t           dev_wdata;
  bright_t           dev_rdata;

  modport master (
    output cmd_valid, cmd_ch, cmd_target, cmd_step,
    output cpu_address, cpu_enable, cpu_mode, cpu_data_in,
    output dev_rdata,
    input  cmd_ready, cpu_data_out,
    input  dev_address, dev_enable, dev_mode, dev_wdata
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_target, cmd_step,
    input  cpu_address, cpu_enable, cpu_mode, cpu_data_in,
    input  dev_rdata,
    output cmd_ready, cpu_data_out,
    output dev_address, dev_enable, dev_mode, dev_wdata
  );

endinterface

// File: rtl/led_fade_tick.sv
// Free-running prescaler: one-cycle tick_o every TICK_DIV clocks.
// Counter runs 0..TICK_DIV-1; the tick coincides with the wrap.
module led_fade_tick #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// Fade engine + CPU-priority bus mux in front of the LED PWM device.
// LED_FADE_CANCEL_EN: a CPU write to a fading channel cancels its fade.
module led_fade_sequencer
  import led_fade_pkg::*;
#(
  parameter int NUM_CH   = 10,
  parameter int TICK_DIV = 1024,
  parameter int ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_fade_sequencer_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic [CH_W-1:0]       done_ch
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   i_q, i_d;
  bright_t           next_q, next_d;
  bright_t           shadow_q [NUM_CH];
  bright_t           shadow_d [NUM_CH];
  bright_t           target_q [NUM_CH];
  bright_t           target_d [NUM_CH];
  bright_t           step_q   [NUM_CH];
  bright_t           step_d   [NUM_CH];
  logic [NUM_CH-1:0] active_q, active_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;

  logic            tick;
  logic            last_ch;
  logic            snoop;
  logic [CH_W-1:0] snoop_ch;
  logic            accept;
  logic            drop;
  logic            fwr;

  led_fade_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (reset_n),
    .tick_o (tick)
  );

  assign last_ch  = (i_q == CH_W'(NUM_CH - 1));
  assign snoop_ch = CH_W'(bus.cpu_address);
  assign snoop    = bus.cpu_enable & bus.cpu_mode
                  & (int'(bus.cpu_address) < NUM_CH);
  assign accept   = bus.cmd_valid & (state_q == IDLE)
                  & (int'(bus.cmd_ch) < NUM_CH);

`ifdef LED_FADE_CANCEL_EN
  // A cancelled channel's pending write is skipped, not performed
  assign drop = ~active_q[i_q];
`else
  assign drop = 1'b0;
`endif

  assign fwr = (state_q == WRITE) & ~drop;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    next_d    = next_q;
    shadow_d  = shadow_q;
    target_d  = target_q;
    step_d    = step_q;
    active_d  = active_q;
    pend_d    = pend_q | tick;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;

    if (snoop) begin
      shadow_d[snoop_ch] = bus.cpu_data_in;
`ifdef LED_FADE_CANCEL_EN
      active_d[snoop_ch] = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d[bus.cmd_ch] = bus.cmd_target;
          step_d[bus.cmd_ch]   = bus.cmd_step;
          active_d[bus.cmd_ch] =
            (bus.cmd_target != shadow_q[bus.cmd_ch]);
          if (bus.cmd_target == shadow_q[bus.cmd_ch]) begin
            done_d    = 1'b1;
            done_ch_d = bus.cmd_ch;
          end
        end
        if (pend_q) begin
          state_d = SCAN;
          i_d     = '0;
          pend_d  = tick;
        end
      end
      SCAN: begin
        if (active_q[i_q]) begin
          next_d  = step_toward(shadow_q[i_q],
                                target_q[i_q],
                                step_q[i_q]);
          state_d = WRITE;
        end else if (last_ch) begin
          state_d = IDLE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      WRITE: begin
        // CPU owns the bus: hold until a free cycle
        if (!bus.cpu_enable || drop) begin
          if (!drop) begin
            shadow_d[i_q] = next_q;
            if (next_q == target_q[i_q]) begin
              active_d[i_q] = 1'b0;
              done_d        = 1'b1;
              done_ch_d     = i_q;
            end
          end
          if (last_ch) begin
            state_d = IDLE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      next_q    <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= '0;
        target_q[k] <= '0;
        step_q[k]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      next_q    <= next_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      shadow_q  <= shadow_d;
      target_q  <= target_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    bus.dev_enable  = 1'b0;
    bus.dev_mode    = 1'b0;
    bus.dev_address = '0;
    bus.dev_wdata   = '0;
    if (bus.cpu_enable) begin
      bus.dev_enable  = 1'b1;
      bus.dev_mode    = bus.cpu_mode;
      bus.dev_address = bus.cpu_address;
      bus.dev_wdata   = bus.cpu_data_in;
    end else if (fwr) begin
      bus.dev_enable  = 1'b1;
      bus.dev_mode    = 1'b1;
      bus.dev_address = ADDR_W'(i_q);
      bus.dev_wdata   = next_q;
    end
  end

  assign bus.cmd_ready    = reset_n & (state_q == IDLE);
  assign bus.cpu_data_out = bus.dev_rdata;
  assign busy             = |active_q;
  assign done             = done_q;
  assign done_ch          = done_ch_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with a write/done scoreboard.
// Build with +define+LED_FADE_CANCEL_EN to exercise fade cancellation.
module tb_led_fade_sequencer;

  localparam int T = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] done_ch;

  always #5 clk = ~clk;

  led_fade_sequencer_if #(.ADDR_W(5)) bus ();

  led_fade_sequencer #(
    .NUM_CH   (10),
    .TICK_DIV (T),
    .ADDR_W   (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done),
    .done_ch (done_ch)
  );

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int last_wr_cyc = -1;
  int last_done_cyc = -1;
  int base = 0;
  int acc = 0;
  int e = 0;

  logic [12:0] wq [$];
  logic [3:0]  dq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.dev_enable && !bus.cpu_enable) begin
      chk("wr_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0)
        chk("fader_wr",
            {bus.dev_mode, bus.dev_address, bus.dev_wdata},
            {1'b1, wq.pop_front()});
      last_wr_cyc = cyc;
    end
    if (reset_n && done) begin
      chk("done_expected", 32'(dq.size() != 0), 1);
      if (dq.size() != 0)
        chk("done_ch", done_ch, dq.pop_front());
      last_done_cyc = cyc;
    end
  end

  function automatic int next_at(input int c, input int lo);
    int r;
    r = base + c;
    while (r < lo) r += T;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic send_cmd(input int ch, input int tgt, input int st);
    logic ok;
    ok = 1'b0;
    bus.cmd_ch     = 4'(ch);
    bus.cmd_target = 8'(tgt);
    bus.cmd_step   = 8'(st);
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        ok  = 1'b1;
        step();
        break;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 1);
  endtask

  task automatic cpu_wr(input int a, input int d);
    bus.cpu_enable  = 1'b1;
    bus.cpu_mode    = 1'b1;
    bus.cpu_address = 5'(a);
    bus.cpu_data_in = 8'(d);
    @(negedge clk);
    chk("cpu_pass",
        {bus.dev_enable, bus.dev_mode, bus.dev_address, bus.dev_wdata},
        {1'b1, 1'b1, 5'(a), 8'(d)});
    step();
    bus.cpu_enable = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (wq.size() == 0 && dq.size() == 0) break;
      step();
    end
    chk("drain_wq", 32'(wq.size()), 0);
    chk("drain_dq", 32'(dq.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_ch      = '0;
    bus.cmd_target  = '0;
    bus.cmd_step    = '0;
    bus.cpu_address = '0;
    bus.cpu_enable  = 1'b0;
    bus.cpu_mode    = 1'b0;
    bus.cpu_data_in = '0;
    bus.dev_rdata   = '0;

    #12;
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_dev_en", bus.dev_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done, done_ch}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    @(negedge clk);
    chk("ready_idle", bus.cmd_ready, 1);
    step();

    // fade up 0 -> 100 in steps of 40
    wq.push_back({5'd2, 8'd40});
    wq.push_back({5'd2, 8'd80});
    wq.push_back({5'd2, 8'd100});
    dq.push_back(4'd2);
    send_cmd(2, 100, 40);
    @(negedge clk);
    chk("busy_up", busy, 1);
    step();
    drain(4 * T);
    step();
    @(negedge clk);
    chk("busy_fall", busy, 0);
    step();

    // fade down 200 -> 0 with step 255, no wrap
    cpu_wr(5, 200);
    wq.push_back({5'd5, 8'd0});
    dq.push_back(4'd5);
    send_cmd(5, 0, 255);
    drain(3 * T);
    base = last_wr_cyc - 5;

    bus.cpu_enable  = 1'b1;
    bus.cpu_mode    = 1'b0;
    bus.cpu_address = 5'd3;
    bus.dev_rdata   = 8'hA5;
    @(negedge clk);
    chk("cpu_rd_data", bus.cpu_data_out, 8'hA5);
    chk("cpu_rd_bus", {bus.dev_enable, bus.dev_mode, bus.dev_address},
        {1'b1, 1'b0, 5'd3});
    step();
    bus.cpu_enable = 1'b0;

    // CPU occupies the bus across the fader WRITE
    wq.push_back({5'd3, 8'd50});
    dq.push_back(4'd3);
    send_cmd(3, 50, 50);
    e = next_at(3, cyc + 4);
    goto(e - 2);
    bus.cpu_enable  = 1'b1;
    bus.cpu_mode    = 1'b1;
    bus.cpu_address = 5'd20;
    for (int j = 0; j < 7; j++) begin
      bus.cpu_data_in = 8'(8'h30 + j);
      @(negedge clk);
      chk("stall_cpu",
          {bus.dev_enable, bus.dev_mode, bus.dev_address, bus.dev_wdata},
          {1'b1, 1'b1, 5'd20, 8'(8'h30 + j)});
      step();
    end
    bus.cpu_enable = 1'b0;
    drain(2 * T);
    chk("stall_wr_cyc", last_wr_cyc, e + 5);

    // channels 0 and 9 on the same tick
    e = next_at(0, cyc + 2);
    goto(e + 12);
    wq.push_back({5'd0, 8'd10});
    wq.push_back({5'd9, 8'd20});
    dq.push_back(4'd0);
    dq.push_back(4'd9);
    send_cmd(0, 10, 10);
    send_cmd(9, 20, 20);
    e = e + T;
    goto(e - 1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("ready_scan", bus.cmd_ready, 0);
      step();
    end
    @(negedge clk);
    chk("ready_after", bus.cmd_ready, 1);
    chk("ch9_wr_cyc", last_wr_cyc, e + 10);
    step();
    drain(2 * T);

    // CPU write lands mid-fade on channel 6
    wq.push_back({5'd6, 8'd30});
`ifndef LED_FADE_CANCEL_EN
    wq.push_back({5'd6, 8'd100});
    dq.push_back(4'd6);
`endif
    send_cmd(6, 100, 30);
    e = next_at(6, cyc + 2);
    goto(e + 3);
    cpu_wr(6, 90);
    drain(3 * T);
    repeat (T + 2) step();
    chk("snoop_idle_wq", 32'(wq.size()), 0);
    chk("snoop_busy", busy, 0);

    // target equals shadow: no write, done next cycle; ch 12 ignored
    step();
    dq.push_back(4'd2);
    send_cmd(2, 100, 0);
    @(negedge clk);
    #1;
    chk("eq_done_cyc", last_done_cyc, acc + 1);
    chk("eq_busy", busy, 0);
    step();
    send_cmd(12, 77, 5);
    repeat (2 * T) step();
    chk("ch12_dq", 32'(dq.size()), 0);
    chk("ch12_busy", busy, 0);

    // asynchronous reset during a fader write
    send_cmd(4, 200, 10);
    e = next_at(4, cyc + 2);
    goto(e);
    #1;
    chk("pre_rst_wr",
        {bus.dev_enable, bus.dev_address, bus.dev_wdata},
        {1'b1, 5'd4, 8'd10});
    reset_n = 1'b0;
    #1;
    chk("arst_dev",
        {bus.dev_enable, bus.dev_mode, bus.dev_address, bus.dev_wdata},
        0);
    chk("arst_busy", busy, 0);
    chk("arst_done", {done, done_ch}, 0);
    chk("arst_ready", bus.cmd_ready, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1);
    step();
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
